// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan controller: glyph table,
// anode idle pattern and the per-slot phase encoding.
package seg7_pkg;

    localparam logic [7:0] ANODE_OFF = 8'hFF;

    // Active-low segments, bit 6 = a ... bit 0 = g, indexed by hex value.
    localparam logic [6:0] GLYPH [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } slot_phase_t;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Display-side bundle of the scan controller: page control, the four
// candidate words and the registered display outputs.
interface seg7_scan_ctrl_if;

    logic        page_step;
    logic [31:0] src0;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] src3;
    logic [7:0]  anode;
    logic [6:0]  data;
    logic [1:0]  page;
    logic        frame_start;

    modport master (
        output page_step, src0, src1, src2, src3,
        input  anode, data, page, frame_start
    );

    modport slave (
        input  page_step, src0, src1, src2, src3,
        output anode, data, page, frame_start
    );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = GLYPH[nib];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with anti-ghost blanking,
// page-selected source word and a frame-synchronous shadow register.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int TICK_DIV  = 100000,
    parameter int BLANK_CYC = 4
)(
    input  logic             clk,
    input  logic             rst,
    seg7_scan_ctrl_if.slave  bus
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] BLANK_END = TW'(BLANK_CYC);

    logic [TW-1:0] tick_cnt;
    logic [2:0]    digit_idx;
    logic [1:0]    page_q;
    logic [31:0]   shadow;
    logic          step_q;
    slot_phase_t   phase;
    logic [7:0]    anode_q;
    logic [6:0]    data_q;
    logic          frame_start_q;

    logic [TW-1:0] tick_nxt;
    logic [2:0]    digit_nxt;
    logic [1:0]    page_nxt;
    logic [31:0]   shadow_nxt;
    logic [31:0]   src_sel;
    logic [3:0]    nib_nxt;
    logic [6:0]    glyph_nxt;
    logic          boundary;

    always_comb begin
        unique case (page_q)
            2'd0:    src_sel = bus.src0;
            2'd1:    src_sel = bus.src1;
            2'd2:    src_sel = bus.src2;
            default: src_sel = bus.src3;
        endcase
    end

    // Next-state timing; outputs are registered from these so they line up
    // with the counters in the same cycle.
    always_comb begin
        tick_nxt   = tick_cnt + TW'(1);
        digit_nxt  = digit_idx;
        shadow_nxt = shadow;
        page_nxt   = page_q;
        boundary   = (tick_cnt == TICK_LAST) && (digit_idx == 3'd0);
        if (tick_cnt == TICK_LAST) begin
            tick_nxt  = '0;
            digit_nxt = digit_idx - 3'd1;
        end
        // Capture uses the page held before this cycle; an edge arriving now
        // only takes effect on the following frame.
        if (boundary) begin
            shadow_nxt = src_sel;
        end
        if (bus.page_step && !step_q) begin
            page_nxt = page_q + 2'd1;
        end
        nib_nxt = shadow_nxt[{digit_nxt, 2'b00} +: 4];
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nib (nib_nxt),
        .seg (glyph_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt      <= '0;
            digit_idx     <= 3'd7;
            page_q        <= 2'd0;
            shadow        <= '0;
            step_q        <= 1'b0;
            phase         <= BLANK;
            anode_q       <= ANODE_OFF;
            data_q        <= GLYPH[0];
            frame_start_q <= 1'b0;
        end else begin
            tick_cnt      <= tick_nxt;
            digit_idx     <= digit_nxt;
            page_q        <= page_nxt;
            shadow        <= shadow_nxt;
            step_q        <= bus.page_step;
            data_q        <= glyph_nxt;
            frame_start_q <= (tick_nxt == TICK_LAST) && (digit_nxt == 3'd0);
            if (tick_nxt < BLANK_END) begin
                phase   <= BLANK;
                anode_q <= ANODE_OFF;
            end else begin
                phase   <= DRIVE;
                anode_q <= ~(8'h01 << digit_nxt);
            end
        end
    end

    assign bus.anode       = anode_q;
    assign bus.data        = data_q;
    assign bus.page        = page_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with TICK_DIV=8, BLANK_CYC=2.
module tb_seg7_scan_ctrl;

    localparam int TD = 8;
    localparam int BC = 2;
    localparam int FRAME = 8 * TD;

    typedef struct {
        logic [7:0] anode;
        logic [6:0] data;
        logic [1:0] page;
        logic       fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    exp_t        q[$];
    int          m_cyc = 0;
    logic [1:0]  m_page = 2'd0;
    logic [31:0] m_shadow = '0;
    logic        m_stepq = 1'b0;
    string       phase_tag = "reset";
    int          first_fs = -1;

    seg7_scan_ctrl_if bus ();

    seg7_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYC(BC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] glyph_ref(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    // Advance the reference by one clock using the inputs now applied, queue
    // the expected outputs, then compare them against the DUT after the edge.
    task automatic cycle();
        exp_t e;
        exp_t o;
        int   tk;
        int   dg;
        logic [31:0] cur_src;
        if (rst) begin
            m_cyc = 0; m_page = 2'd0; m_shadow = '0; m_stepq = 1'b0;
        end else begin
            tk = m_cyc % TD;
            dg = 7 - ((m_cyc / TD) % 8);
            case (m_page)
                2'd0: cur_src = bus.src0;
                2'd1: cur_src = bus.src1;
                2'd2: cur_src = bus.src2;
                default: cur_src = bus.src3;
            endcase
            if (tk == TD - 1 && dg == 0) m_shadow = cur_src;
            if (bus.page_step && !m_stepq) m_page = m_page + 2'd1;
            m_stepq = bus.page_step;
            m_cyc++;
        end
        tk = m_cyc % TD;
        dg = 7 - ((m_cyc / TD) % 8);
        e.anode = (tk < BC) ? 8'hFF : ~(8'h01 << dg);
        e.data  = glyph_ref(m_shadow[dg*4 +: 4]);
        e.page  = m_page;
        e.fs    = (tk == TD - 1) && (dg == 0);
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk({phase_tag, ":queue_empty"}, 32'd1, 32'd0);
        end else begin
            o = q.pop_front();
            chk({phase_tag, ":anode"}, {24'd0, bus.anode}, {24'd0, o.anode});
            chk({phase_tag, ":data"}, {25'd0, bus.data}, {25'd0, o.data});
            chk({phase_tag, ":page"}, {30'd0, bus.page}, {30'd0, o.page});
            chk({phase_tag, ":frame_start"}, {31'd0, bus.frame_start}, {31'd0, o.fs});
            if (bus.frame_start === 1'b1 && first_fs < 0) first_fs = m_cyc;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_to(input int pos);
        for (int i = 0; i < FRAME && (m_cyc % FRAME) != pos; i++) cycle();
    endtask

    task automatic pulse_step();
        bus.page_step = 1'b1;
        run(2);
        bus.page_step = 1'b0;
        run(2);
    endtask

    initial begin
        bus.page_step = 1'b0;
        bus.src0 = 32'h1234_ABCD;
        bus.src1 = 32'h1111_1111;
        bus.src2 = 32'h2222_2222;
        bus.src3 = 32'hDEAD_BEEF;
        rst = 1'b1;
        run(2);
        rst = 1'b0;

        phase_tag = "frame1_zeros";
        run(FRAME);
        chk("first_frame_start_cycle", first_fs, FRAME - 1);
        phase_tag = "frame2_src0";
        run(FRAME);

        phase_tag = "src_change_midframe";
        run(20);
        bus.src0 = 32'hFFFF_FFFF;
        run(FRAME - 20);
        phase_tag = "frame_all_F";
        run(10);

        phase_tag = "page_steps";
        pulse_step();
        pulse_step();
        pulse_step();
        chk("page_after_three_edges", {30'd0, bus.page}, 32'd3);
        run_to(0);
        phase_tag = "frame_src3";
        run(20);
        pulse_step();
        chk("page_after_fourth_edge", {30'd0, bus.page}, 32'd0);
        run_to(FRAME - 1);

        phase_tag = "edge_on_boundary";
        bus.page_step = 1'b1;
        cycle();
        bus.page_step = 1'b0;
        chk("page_after_boundary_edge", {30'd0, bus.page}, 32'd1);
        run(FRAME);
        phase_tag = "frame_src1";
        run(FRAME);

        phase_tag = "rst_midframe";
        run_to(3 * TD + 4);
        rst = 1'b1;
        cycle();
        chk("rst_anode", {24'd0, bus.anode}, 32'hFF);
        chk("rst_data", {25'd0, bus.data}, 32'b0000001);
        chk("rst_page", {30'd0, bus.page}, 32'd0);
        rst = 1'b0;
        phase_tag = "after_rst";
        run(FRAME + 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
